instr_encoder: RTL
==================

# instr_encoder

Streaming MIPS instruction encoder: accepts decoded instruction descriptions (kind plus register/immediate fields) and emits packed 32-bit instruction words with sequential word addresses, ready to write into instruction memory. It is the producer-side counterpart of the main decoder, emitting exactly the opcode set the single-cycle control decodes: RTYPE, LW, SW, BEQ, ADDI, J, ORI, BNE. It sits between a test/boot loader and the instruction memory write port.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first emitted word.
- ERR_W, 8: width of the illegal-request counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: drops the pending word and reloads the address and counters.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_kind  in  4  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6 ORI, 7 BNE; 8–15 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  immediate or branch offset, passed verbatim.
- in_target  in  26  jump target field.
- out_valid  out  1  packed word available.
- out_ready  in  1  word consumed when out_valid && out_ready.
- out_instr  out  32  packed instruction.
- out_addr  out  32  byte address of out_instr.
- word_count  out  32  number of words consumed since reset/clear.
- err  out  1  sticky flag: at least one illegal kind was seen.
- err_count  out  ERR_W  number of illegal requests, saturating.

## Operation
- Packing rules:
  - RTYPE = {6'b000000, rs, rt, rd, shamt, funct}.
  - LW/SW/BEQ/ADDI/ORI/BNE = {op, rs, rt, imm}, with op 100011/101011/000100/001000/001101/000101.
  - J = {6'b000010, target}.
  - Unused input fields are ignored.
- Output register: a single-entry buffer holding out_instr, out_addr and out_valid.
  - in_ready = !clear && (!out_valid || out_ready); this is a full-throughput pass-through.
- Address counter `addr` (32 bits) starts at BASE_ADDR.
  - out_addr equals addr at the time the word is loaded.
  - addr advances by 4 on each accepted legal request; it wraps modulo 2^32 with no flag.
- word_count increments on each output handshake.
- Illegal kind (8–15):
  - The request is accepted normally, and no word is produced.
  - addr does not advance.
  - err is set.
  - err_count increments and saturates at all-ones.
  - If the output handshake completes in the same cycle, out_valid falls.
- Simultaneous output handshake and legal input acceptance: the buffer reloads, out_valid stays 1, and word_count increments.
- clear has priority over all handshakes in its cycle:
  - out_valid goes to 0 and addr goes to BASE_ADDR.
  - word_count, err and err_count go to 0.
  - A word presented on the output during clear is not counted.
- Reset values: out_valid 0, out_instr 0, out_addr BASE_ADDR, addr BASE_ADDR, word_count 0, err 0, err_count 0.
  - Asserting reset mid-transfer discards the pending word immediately.

## Timing
- Latency is 1 cycle. A request accepted at edge N appears on out_* after edge N.
- Throughput is 1 word/cycle while out_ready is held high.
- out_instr and out_addr are held stable while out_valid && !out_ready.
- in_ready is combinational from out_valid, out_ready and clear. There are no other combinational input-to-output paths.
- err and err_count update at the edge that accepts the illegal request.

## Structure
- Shared package mips_pkg holds:
  - the instruction-kind enum (4 bits);
  - the 6-bit opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_ORI, OP_BNE, with the same values the main decoder uses.
- One combinational sub-module, instr_field_pack, maps kind and fields to {instr, legal}.
- instr_encoder contains only the handshake buffer, the counters and the error logic.

## Test plan
- Basic packing:
  - ADDI rs=0 rt=8 imm=0x0005 -> out_instr 0x20080005, out_addr 0x0.
  - Next request RTYPE rs=9 rt=10 rd=8 shamt=0 funct=0x20 -> 0x012A4020 at out_addr 0x4.
- Remaining formats:
  - LW rs=0 rt=2 imm=0x0050 -> 0x8C020050.
  - J target=0x0000011 -> 0x08000011.
  - BNE rs=1 rt=0 imm=0xFFFE -> 0x1420FFFE.
  - Addresses 0x0, 0x4, 0x8 in order.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable, only one word buffered.
  - Release out_ready -> back-to-back words with no gap and word_count correct.
- Illegal kind:
  - in_kind=9 between two legal ADDIs -> no word for it, err=1, err_count=1, second ADDI at out_addr 0x4.
  - Send 300 illegal requests -> err_count saturates at 255.
- clear:
  - Assert clear while out_valid=1 and out_ready=1 -> next cycle out_valid=0, word_count=0, err=0.
  - Next legal word appears at BASE_ADDR.
- Async reset and wrap:
  - Assert reset between clock edges with a word pending -> out_valid drops immediately and all reset values hold.
  - With BASE_ADDR=0xFFFF_FFFC, the second word has out_addr 0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction kinds and the opcode values the main decoder uses.
package mips_pkg;

  typedef enum logic [3:0] {
    KIND_RTYPE = 4'd0,
    KIND_LW    = 4'd1,
    KIND_SW    = 4'd2,
    KIND_BEQ   = 4'd3,
    KIND_ADDI  = 4'd4,
    KIND_J     = 4'd5,
    KIND_ORI   = 4'd6,
    KIND_BNE   = 4'd7
  } instr_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  function automatic logic [31:0] pack_itype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: maps an instruction kind plus fields to a 32-bit MIPS word and a legal flag.
module instr_field_pack
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] instr,
  output logic        legal
);

  // Select the format for the kind; kinds 8-15 are flagged illegal with a zero word.
  always_comb begin
    instr = 32'd0;
    legal = 1'b1;
    case (instr_kind_e'(kind))
      KIND_RTYPE: instr = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_LW:    instr = pack_itype(OP_LW, rs, rt, imm);
      KIND_SW:    instr = pack_itype(OP_SW, rs, rt, imm);
      KIND_BEQ:   instr = pack_itype(OP_BEQ, rs, rt, imm);
      KIND_ADDI:  instr = pack_itype(OP_ADDI, rs, rt, imm);
      KIND_J:     instr = {OP_J, target};
      KIND_ORI:   instr = pack_itype(OP_ORI, rs, rt, imm);
      KIND_BNE:   instr = pack_itype(OP_BNE, rs, rt, imm);
      default: begin
        instr = 32'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: single-entry output buffer, word address and
// handshake counters, plus sticky/saturating tracking of illegal request kinds.
module instr_encoder
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_kind,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [5:0]       in_funct,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic [31:0]      word_count,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  logic [31:0]      packed_instr;
  logic             packed_legal;
  logic             accept;
  logic             out_fire;

  logic             out_valid_q,  out_valid_d;
  logic [31:0]      out_instr_q,  out_instr_d;
  logic [31:0]      out_addr_q,   out_addr_d;
  logic [31:0]      addr_q,       addr_d;
  logic [31:0]      word_count_q, word_count_d;
  logic             err_q,        err_d;
  logic [ERR_W-1:0] err_count_q,  err_count_d;

  instr_field_pack u_pack (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .funct  (in_funct),
    .imm    (in_imm),
    .target (in_target),
    .instr  (packed_instr),
    .legal  (packed_legal)
  );

  assign in_ready = !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Next-state for buffer, address and counters; clear overrides every handshake.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    err_count_d  = err_count_q;
    if (clear) begin
      out_valid_d  = 1'b0;
      addr_d       = BASE_ADDR;
      word_count_d = 32'd0;
      err_d        = 1'b0;
      err_count_d  = {ERR_W{1'b0}};
    end else begin
      if (out_fire) begin
        out_valid_d  = 1'b0;
        word_count_d = word_count_q + 32'd1;
      end else begin
        out_valid_d  = out_valid_q;
      end
      // Illegal kinds are consumed without producing a word or advancing the address.
      if (accept && packed_legal) begin
        out_valid_d = 1'b1;
        out_instr_d = packed_instr;
        out_addr_d  = addr_q;
        addr_d      = addr_q + 32'd4;
      end else if (accept) begin
        err_d = 1'b1;
        if (err_count_q != {ERR_W{1'b1}}) begin
          err_count_d = err_count_q + ERR_W'(1);
        end else begin
          err_count_d = err_count_q;
        end
      end else begin
        err_d = err_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= 32'd0;
      out_addr_q   <= BASE_ADDR;
      addr_q       <= BASE_ADDR;
      word_count_q <= 32'd0;
      err_q        <= 1'b0;
      err_count_q  <= {ERR_W{1'b0}};
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = out_addr_q;
  assign word_count = word_count_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule
